fetch_unit: RTL

Instruction fetch stage that sits directly upstream of control_component. It holds the PC and issues one request at a time to instruction memory, which can take a variable number of cycles to answer. It registers the returned 16-bit instruction and presents op = inst[15:12] to control_component with a valid/ready handshake. Taken jal/jalr/bne (PCWRITE) arrives as a redirect; the fetch stage applies it and discards any stale fetch.

---
 rtl/proc_pkg.sv | 30 +++
 rtl/pc_reg.sv | 46 ++++
 rtl/fetch_unit.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/proc_pkg.sv
// Shared definitions for the processor front end: default widths, fetch FSM
// encoding and the opcode values that control_component decodes.
package proc_pkg;

  localparam int ADDR_W_DEF  = 16;
  localparam int INST_W_DEF  = 16;
  localparam int PC_STEP_DEF = 2;
  localparam logic [ADDR_W_DEF-1:0] RESET_PC_DEF = 16'h0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    WAIT  = 2'd2,
    HOLD  = 2'd3
  } fetch_state_e;

  // Opcode field values, inst[15:12]
  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_JALR = 4'b0100;
  localparam logic [3:0] OP_ADDI = 4'b0101;
  localparam logic [3:0] OP_JAL  = 4'b0110;
  localparam logic [3:0] OP_LW   = 4'b1000;
  localparam logic [3:0] OP_SW   = 4'b1001;
  localparam logic [3:0] OP_BEQ  = 4'b1010;
  localparam logic [3:0] OP_BNE  = 4'b1011;

endpackage

// File: rtl/pc_reg.sv
// Program counter register with its next-PC mux: a redirect target always wins,
// otherwise step sequentially when advance is set, otherwise hold.
module pc_reg
  import proc_pkg::*;
#(
  parameter int                ADDR_W   = ADDR_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEF,
  parameter int                PC_STEP  = PC_STEP_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              advance,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_inc,
  output logic [ADDR_W-1:0] pc_next
);

  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_d;

  // Addition wraps naturally at 2^ADDR_W
  assign pc_inc = pc_q + ADDR_W'(PC_STEP);

  always_comb begin
    pc_d = pc_q;
    if (redirect) begin
      pc_d = redirect_pc;
    end else if (advance) begin
      pc_d = pc_inc;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc      = pc_q;
  assign pc_next = pc_d;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: one outstanding imem request at a time, registered
// instruction presented downstream with valid/ready, redirects discard stale fetches.
module fetch_unit
  import proc_pkg::*;
#(
  parameter int                ADDR_W   = ADDR_W_DEF,
  parameter int                INST_W   = INST_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEF,
  parameter int                PC_STEP  = PC_STEP_DEF
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [INST_W-1:0] imem_rdata,
  input  logic              imem_valid,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              inst_ready,
  output logic              inst_valid,
  output logic [INST_W-1:0] inst,
  output logic [3:0]        op,
  output logic [ADDR_W-1:0] inst_pc,
  output logic [ADDR_W-1:0] pc_plus
);

  fetch_state_e      state_q, state_d;
  logic              kill_q, kill_d;
  logic              inst_valid_q, inst_valid_d;
  logic [INST_W-1:0] inst_q, inst_d;
  logic [ADDR_W-1:0] inst_pc_q, inst_pc_d;
  logic [ADDR_W-1:0] pc_plus_q, pc_plus_d;
  logic              imem_req_q, imem_req_d;
  logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;

  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] pc_next;
  logic              accept_resp;

  // A response is consumed only if nothing has invalidated it
  assign accept_resp = (state_q == WAIT) && imem_valid && !kill_q && !redirect;

  pc_reg #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC),
    .PC_STEP  (PC_STEP)
  ) u_pc_reg (
    .clk         (clk),
    .reset       (reset),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .advance     (accept_resp),
    .pc          (pc),
    .pc_inc      (pc_inc),
    .pc_next     (pc_next)
  );

  always_comb begin
    state_d      = state_q;
    kill_d       = kill_q;
    inst_valid_d = inst_valid_q;
    inst_d       = inst_q;
    inst_pc_d    = inst_pc_q;
    pc_plus_d    = pc_plus_q;

    unique case (state_q)
      IDLE: begin
        state_d = FETCH;
      end
      FETCH: begin
        // The request still goes out; a redirect only marks its answer stale
        state_d = WAIT;
        if (redirect) begin
          kill_d = 1'b1;
        end
      end
      WAIT: begin
        if (imem_valid) begin
          if (kill_q || redirect) begin
            kill_d  = 1'b0;
            state_d = FETCH;
          end else begin
            inst_d       = imem_rdata;
            inst_pc_d    = pc;
            pc_plus_d    = pc_inc;
            inst_valid_d = 1'b1;
            state_d      = HOLD;
          end
        end else if (redirect) begin
          kill_d = 1'b1;
        end
      end
      HOLD: begin
        if (redirect || inst_ready) begin
          inst_valid_d = 1'b0;
          state_d      = FETCH;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Request strobe and address are registered from next-state so they are
  // glitch-free and imem_addr always equals the pc held during FETCH.
  always_comb begin
    imem_req_d  = (state_d == FETCH);
    imem_addr_d = imem_req_d ? pc_next : '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      kill_q       <= 1'b0;
      inst_valid_q <= 1'b0;
      inst_q       <= '0;
      inst_pc_q    <= '0;
      pc_plus_q    <= '0;
      imem_req_q   <= 1'b0;
      imem_addr_q  <= '0;
    end else begin
      state_q      <= state_d;
      kill_q       <= kill_d;
      inst_valid_q <= inst_valid_d;
      inst_q       <= inst_d;
      inst_pc_q    <= inst_pc_d;
      pc_plus_q    <= pc_plus_d;
      imem_req_q   <= imem_req_d;
      imem_addr_q  <= imem_addr_d;
    end
  end

  assign imem_req   = imem_req_q;
  assign imem_addr  = imem_addr_q;
  assign inst_valid = inst_valid_q;
  assign inst       = inst_q;
  assign op         = inst_q[INST_W-1 -: 4];
  assign inst_pc    = inst_pc_q;
  assign pc_plus    = pc_plus_q;

endmodule
